// File: rtl/player_motion_pkg.sv
// Shared types and constants for the player sprite motion block and the display stage.
package player_motion_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int VY_W    = 6;
    localparam int CALC_W  = 11;
    localparam int FRAME_W = 4;

    localparam int SPRITE_W_DEF = 47;
    localparam int X_MAX_DEF    = 550;
    localparam int Y_FLOOR_DEF  = 359;

    typedef enum logic [1:0] {
        ANIM_IDLE = 2'd0,
        ANIM_RUN  = 2'd1,
        ANIM_AIR  = 2'd2
    } anim_state_e;

    // -1 for left only, +1 for right only, 0 for both or neither.
    function automatic logic signed [1:0] intent_dir(input logic left, input logic right);
        if (left && !right)      return -2'sd1;
        else if (right && !left) return 2'sd1;
        else                     return 2'sd0;
    endfunction

endpackage

// File: rtl/anim_frame_counter.sv
// Animation frame counter: divides game ticks by FRAME_DIV, restarts on any state change.
module anim_frame_counter
    import player_motion_pkg::*;
#(
    parameter int FRAME_DIV = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tick,
    input  logic               state_change,
    output logic [FRAME_W-1:0] frame_idx
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    always_comb begin
        div_d   = div_q;
        frame_d = frame_q;
        if (tick) begin
            if (state_change) begin
                div_d   = '0;
                frame_d = '0;
            end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d   = '0;
                frame_d = frame_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q   <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end

    assign frame_idx = frame_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// Player sprite position, facing and IDLE/RUN/AIR state, advanced once per game tick.
// Jumping (AIR state and vertical motion) exists only when PLAYER_JUMP_EN is defined.
module player_motion_ctrl
    import player_motion_pkg::*;
#(
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_FLOOR   = Y_FLOOR_DEF,
    parameter int SPRITE_W  = SPRITE_W_DEF,
    parameter int STEP      = 2,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int VY_MAX    = 12,
    parameter int FRAME_DIV = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tick,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               key_jump,
    output logic [X_W-1:0]     pos_x,
    output logic [Y_W-1:0]     pos_y,
    output logic [1:0]         anim_state,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               facing_left
);

    localparam logic signed [CALC_W-1:0] STEP_S  = CALC_W'(STEP);
    localparam logic signed [CALC_W-1:0] X_LIM_S = CALC_W'(X_MAX - SPRITE_W + 1);

    anim_state_e          state_q, state_d;
    logic [X_W-1:0]       pos_x_q, pos_x_d;
    logic                 facing_q, facing_d;
    logic signed [1:0]    dir;
    logic                 moving;
    logic signed [CALC_W-1:0] x_ext, x_mv;
    logic [X_W-1:0]       x_sat;
    logic                 state_change;

    assign dir    = intent_dir(key_left, key_right);
    assign moving = (dir != 2'sd0);

    // Horizontal move is computed wide and signed so both edges saturate without wrap.
    always_comb begin
        x_ext = $signed({1'b0, pos_x_q});
        if (dir[1])      x_mv = x_ext - STEP_S;
        else if (dir[0]) x_mv = x_ext + STEP_S;
        else             x_mv = x_ext;
        if (x_mv[CALC_W-1])     x_sat = '0;
        else if (x_mv > X_LIM_S) x_sat = X_W'(X_LIM_S);
        else                     x_sat = x_mv[X_W-1:0];
    end

`ifdef PLAYER_JUMP_EN
    localparam logic signed [VY_W-1:0]   VY_JUMP_S  = VY_W'(-JUMP_V);
    localparam logic signed [VY_W-1:0]   GRAV_S     = VY_W'(GRAVITY);
    localparam logic signed [VY_W-1:0]   VY_MAX_S   = VY_W'(VY_MAX);
    localparam logic signed [CALC_W-1:0] Y_FLOOR_S  = CALC_W'(Y_FLOOR);

    logic [Y_W-1:0]           pos_y_q, pos_y_d;
    logic signed [VY_W-1:0]   vy_q, vy_d, vy_inc, vy_cap;
    logic signed [CALC_W-1:0] y_ext, vy_ext, ny;

    always_comb begin
        y_ext  = $signed({2'b00, pos_y_q});
        vy_ext = {{(CALC_W-VY_W){vy_q[VY_W-1]}}, vy_q};
        ny     = y_ext + vy_ext;
        vy_inc = vy_q + GRAV_S;
        vy_cap = (vy_inc > VY_MAX_S) ? VY_MAX_S : vy_inc;
    end
`endif

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        facing_d = facing_q;
`ifdef PLAYER_JUMP_EN
        pos_y_d  = pos_y_q;
        vy_d     = vy_q;
`endif
        if (tick) begin
            pos_x_d = x_sat;
            if (moving) facing_d = dir[1];
            case (state_q)
                ANIM_IDLE, ANIM_RUN: begin
                    state_d = moving ? ANIM_RUN : ANIM_IDLE;
`ifdef PLAYER_JUMP_EN
                    if (key_jump) begin
                        state_d = ANIM_AIR;
                        vy_d    = VY_JUMP_S;
                    end
`endif
                end
`ifdef PLAYER_JUMP_EN
                ANIM_AIR: begin
                    if (ny[CALC_W-1]) begin
                        pos_y_d = '0;
                        vy_d    = '0;
                    end else if (ny >= Y_FLOOR_S) begin
                        // Landing ignores key_jump; a re-jump is taken on the next tick.
                        pos_y_d = Y_W'(Y_FLOOR);
                        vy_d    = '0;
                        state_d = moving ? ANIM_RUN : ANIM_IDLE;
                    end else begin
                        pos_y_d = ny[Y_W-1:0];
                        vy_d    = vy_cap;
                    end
                end
`endif
                default: state_d = ANIM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ANIM_IDLE;
            pos_x_q  <= '0;
            facing_q <= 1'b0;
`ifdef PLAYER_JUMP_EN
            pos_y_q  <= Y_W'(Y_FLOOR);
            vy_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            facing_q <= facing_d;
`ifdef PLAYER_JUMP_EN
            pos_y_q  <= pos_y_d;
            vy_q     <= vy_d;
`endif
        end
    end

    assign state_change = tick && (state_d != state_q);

    anim_frame_counter #(
        .FRAME_DIV(FRAME_DIV)
    ) u_frame_cnt (
        .clk         (clk),
        .rstn        (rstn),
        .tick        (tick),
        .state_change(state_change),
        .frame_idx   (frame_idx)
    );

    assign pos_x       = pos_x_q;
    assign anim_state  = state_q;
    assign facing_left = facing_q;

`ifdef PLAYER_JUMP_EN
    assign pos_y = pos_y_q;
`else
    logic unused_jump;
    assign unused_jump = key_jump ^ (^{JUMP_V, GRAVITY, VY_MAX});
    assign pos_y = Y_W'(Y_FLOOR);
`endif

endmodule
